// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache miss-fill engine.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int BLOCK_OFFSET_W  = $clog2(WORDS_PER_BLOCK * 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // Word index within a block to byte offset (16-bit words).
    function automatic logic [31:0] word_to_byte(input logic [31:0] word_idx);
        return word_idx << 1;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating word counter used for both the issue and the return side of a fill.
module fill_word_counter #(
    parameter int MAX_COUNT = 8,
    parameter int CNT_W     = $clog2(MAX_COUNT) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count = count_q;
    assign done  = (count_q == CNT_W'(MAX_COUNT));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill engine: streams one block from pipelined memory, then writes metadata.
// Optional performance counters are enabled by defining FILL_PERF_CNT_EN.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = cache_pkg::ADDR_W,
    parameter int DATA_W          = cache_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Miss,
    input  logic [ADDR_W-1:0] Addr_Miss,
    output logic              Busy,
    output logic              Mem_En,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Valid,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [ADDR_W-1:0] Addr_FSM,
    output logic [DATA_W-1:0] DataIn_FSM,
    output logic              Data_WE,
    output logic              MetaData_WE
`ifdef FILL_PERF_CNT_EN
    ,
    output logic [15:0]       Fill_Count,
    output logic [15:0]       Stall_Cycles
`endif
);

    import cache_pkg::*;

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK * 2);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [CNT_W-1:0]  iss_cnt, rcv_cnt;
    logic              iss_done, rcv_done;
    logic              cnt_clr, iss_inc, rcv_inc;

    // Counters are held at zero outside FILL so every fill starts from word 0.
    assign cnt_clr = (state_q != FILL);
    assign iss_inc = (state_q == FILL) && !iss_done;
    assign rcv_inc = (state_q == FILL) && Mem_Valid && !rcv_done;

    fill_word_counter #(.MAX_COUNT(WORDS_PER_BLOCK), .CNT_W(CNT_W)) u_iss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (iss_inc),
        .count (iss_cnt),
        .done  (iss_done)
    );

    fill_word_counter #(.MAX_COUNT(WORDS_PER_BLOCK), .CNT_W(CNT_W)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rcv_inc),
        .count (rcv_cnt),
        .done  (rcv_done)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (Miss) begin
                    state_d = FILL;
                    base_d  = Addr_Miss & ~OFF_MASK;
                end
            end
            FILL: begin
                if (rcv_inc && (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Return-side strobes are combinational from Mem_Valid so data lands the same cycle.
    always_comb begin
        Busy        = (state_q != IDLE);
        Mem_En      = iss_inc;
        Mem_Addr    = '0;
        Data_WE     = rcv_inc;
        DataIn_FSM  = '0;
        Addr_FSM    = '0;
        MetaData_WE = (state_q == DONE);
        if (iss_inc) begin
            Mem_Addr = base_q + ADDR_W'(word_to_byte(32'(iss_cnt)));
        end
        if (rcv_inc) begin
            DataIn_FSM = Mem_Data;
            Addr_FSM   = base_q + ADDR_W'(word_to_byte(32'(rcv_cnt)));
        end else if (state_q == DONE) begin
            Addr_FSM = base_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

`ifdef FILL_PERF_CNT_EN
    logic [15:0] fill_count_q, fill_count_d;
    logic [15:0] stall_q, stall_d;

    // Fill count wraps; stall count sticks at all-ones.
    always_comb begin
        fill_count_d = fill_count_q;
        stall_d      = stall_q;
        if (state_q == DONE) begin
            fill_count_d = fill_count_q + 16'd1;
        end
        if (Busy && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_q <= '0;
            stall_q      <= '0;
        end else begin
            fill_count_q <= fill_count_d;
            stall_q      <= stall_d;
        end
    end

    assign Fill_Count   = fill_count_q;
    assign Stall_Cycles = stall_q;
`endif

endmodule
